// File: rtl/dcfifo_burst_writer.sv
// Burst writer feeding the write side of a dual-clock FIFO.
// Bursts only start when the FIFO is known to have room for a whole
// burst. That room accounts for writes that wrusedw cannot show yet
// because of its update latency.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for src_valid and room for a full burst
// BURST | accepting beats (src_ready=1) until BURST_LEN or src_last
// GAP   | one dead cycle after each burst, src_ready=0
module dcfifo_burst_writer #(
  parameter int LPM_WIDTH  = 8,
  parameter int LPM_WIDTHU = 4,
  parameter int BURST_LEN  = 4,
  parameter int USEDW_LAT  = 3
) (
  input  logic                  wrclk,
  input  logic                  aclr,
  input  logic [LPM_WIDTH-1:0]  src_data,
  input  logic                  src_valid,
  input  logic                  src_last,
  output logic                  src_ready,
  input  logic                  wrfull,
  input  logic [LPM_WIDTHU-1:0] wrusedw,
  output logic [LPM_WIDTH-1:0]  fifo_data,
  output logic                  fifo_wrreq,
  output logic                  burst_active,
  output logic [15:0]           burst_count,
  output logic                  err_overflow
);

  localparam int SW = LPM_WIDTHU + 2;
  localparam int PW = $clog2(USEDW_LAT + 1);
  localparam int BW = $clog2(BURST_LEN) + 1;
  localparam logic [SW-1:0]        FIFO_MAX   = SW'((2 ** LPM_WIDTHU) - 1);
  localparam logic signed [SW-1:0] BURST_NEED = SW'(BURST_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Bit 0 is the write request of the current cycle and bit i is the
  // request from i cycles earlier, so bit 0 also drives fifo_wrreq.
  logic [USEDW_LAT-1:0]   r_wr_hist;
  logic [PW-1:0]          w_pending;
  logic signed [SW-1:0]   w_space_raw;
  logic signed [SW-1:0]   w_space;
  logic                   w_room;
  logic                   w_accept;
  logic                   w_last_beat;
  logic [BW-1:0]          r_beat;
  logic [BW-1:0]          w_beat_inc;
  logic [LPM_WIDTH-1:0]   r_data;
  logic [15:0]            r_count;
  logic                   r_err;

  // Count writes still in flight, meaning not yet visible in wrusedw.
  always_comb begin
    w_pending = '0;
    for (int i = 0; i < USEDW_LAT; i++) begin
      w_pending = w_pending + PW'(r_wr_hist[i]);
    end
  end

  // Free words, clamped to zero on full or a negative result.
  always_comb begin
    w_space_raw = FIFO_MAX - SW'(wrusedw) - SW'(w_pending);
    if (wrfull || w_space_raw[SW-1]) begin
      w_space = '0;
    end else begin
      w_space = w_space_raw;
    end
    w_room      = (w_space >= BURST_NEED);
    w_accept    = src_valid && (r_state == BURST);
    w_beat_inc  = r_beat + BW'(1);
    w_last_beat = (w_beat_inc == BW'(BURST_LEN)) || src_last;
  end

  // State register.
  always_ff @(posedge wrclk or posedge aclr) begin
    if (aclr) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    w_state_nxt  = r_state;
    src_ready    = 1'b0;
    burst_active = 1'b0;
    case (r_state)
      IDLE: begin
        if (src_valid && w_room) begin
          w_state_nxt = BURST;
        end
      end
      BURST: begin
        src_ready    = 1'b1;
        burst_active = 1'b1;
        if (w_accept && w_last_beat) begin
          w_state_nxt = GAP;
        end
      end
      GAP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Write-request history. A new burst needs no clear here, because the
  // history shifts out on its own.
  always_ff @(posedge wrclk or posedge aclr) begin
    if (aclr) begin
      r_wr_hist <= '0;
    end else begin
      r_wr_hist[0] <= w_accept;
      for (int i = 1; i < USEDW_LAT; i++) begin
        r_wr_hist[i] <= r_wr_hist[i-1];
      end
    end
  end

  // Beat counter: zeroed on burst entry, advanced per accepted beat.
  always_ff @(posedge wrclk or posedge aclr) begin
    if (aclr) begin
      r_beat <= '0;
    end else if (r_state == IDLE && w_state_nxt == BURST) begin
      r_beat <= '0;
    end else if (w_accept) begin
      r_beat <= w_beat_inc;
    end
  end

  // Registered FIFO data. It holds its value between writes.
  always_ff @(posedge wrclk or posedge aclr) begin
    if (aclr) begin
      r_data <= '0;
    end else if (w_accept) begin
      r_data <= src_data;
    end
  end

  // Completed-burst counter, wrapping at 16 bits.
  always_ff @(posedge wrclk or posedge aclr) begin
    if (aclr) begin
      r_count <= '0;
    end else if (r_state == BURST && w_state_nxt == GAP) begin
      r_count <= r_count + 16'd1;
    end
  end

  // Sticky overflow flag: a write was issued while the FIFO reported full.
  always_ff @(posedge wrclk or posedge aclr) begin
    if (aclr) begin
      r_err <= 1'b0;
    end else if (r_wr_hist[0] && wrfull) begin
      r_err <= 1'b1;
    end
  end

  assign fifo_wrreq   = r_wr_hist[0];
  assign fifo_data    = r_data;
  assign burst_count  = r_count;
  assign err_overflow = r_err;

endmodule

// File: tb/tb_dcfifo_burst_writer.sv
// Bench for dcfifo_burst_writer. A behavioural model of the burst rules
// and a model of the FIFO occupancy with lagged wrusedw are compared
// against the DUT on every cycle.
module tb_dcfifo_burst_writer;

  localparam int W     = 8;
  localparam int WU    = 4;
  localparam int BL    = 4;
  localparam int LAT   = 3;
  localparam int DEPTH = 16;

  logic          wrclk = 1'b0;
  logic          aclr = 1'b0;
  logic [W-1:0]  src_data;
  logic          src_valid;
  logic          src_last;
  logic          src_ready;
  logic          wrfull;
  logic [WU-1:0] wrusedw;
  logic [W-1:0]  fifo_data;
  logic          fifo_wrreq;
  logic          burst_active;
  logic [15:0]   burst_count;
  logic          err_overflow;

  dcfifo_burst_writer #(
    .LPM_WIDTH (W),
    .LPM_WIDTHU(WU),
    .BURST_LEN (BL),
    .USEDW_LAT (LAT)
  ) dut (
    .wrclk       (wrclk),
    .aclr        (aclr),
    .src_data    (src_data),
    .src_valid   (src_valid),
    .src_last    (src_last),
    .src_ready   (src_ready),
    .wrfull      (wrfull),
    .wrusedw     (wrusedw),
    .fifo_data   (fifo_data),
    .fifo_wrreq  (fifo_wrreq),
    .burst_active(burst_active),
    .burst_count (burst_count),
    .err_overflow(err_overflow)
  );

  always #5 wrclk = ~wrclk;

  int checks = 0;
  int errors = 0;
  int k = 0;

  // Behavioural model state.
  bit         m_busy;
  bit         m_gap;
  int         m_beats;
  bit         m_wrreq;
  logic [7:0] m_data;
  int         m_count;
  bit         m_err;
  bit         wr_h[64];
  int         occ_h[64];

  int         wr_log_cyc[$];
  logic [7:0] wr_log_dat[$];
  int         acc_cyc[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, k, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("src_ready", src_ready, m_busy);
    chk("burst_active", burst_active, m_busy);
    chk("fifo_wrreq", fifo_wrreq, m_wrreq);
    chk("fifo_data", fifo_data, m_data);
    chk("burst_count", burst_count, m_count & 32'hFFFF);
    chk("err_overflow", err_overflow, m_err);
  endtask

  task automatic model_reset();
    m_busy = 0; m_gap = 0; m_beats = 0; m_wrreq = 0;
    m_data = '0; m_count = 0; m_err = 0;
    for (int i = 0; i < 64; i++) begin
      wr_h[i]  = 0;
      occ_h[i] = 0;
    end
  endtask

  // The task is entered at a negedge. It drives the inputs for the next
  // posedge, advances the environment and the model, and then compares
  // at the following negedge. A usedw_force of -1 takes wrusedw from the
  // lagged FIFO model.
  task automatic step(input bit v, input bit l, input logic [7:0] d,
                      input bit full, input int usedw_force, input bit rd);
    int usedw;
    int occ_n;
    int pend;
    int space;
    bit accept;
    usedw = (usedw_force >= 0) ? usedw_force : occ_h[(k - LAT + 1 + 64) % 64];
    src_valid = v;
    src_last  = l;
    src_data  = d;
    wrfull    = full;
    wrusedw   = 4'(usedw);

    occ_n = occ_h[k % 64] + (fifo_wrreq ? 1 : 0);
    checks++;
    if (occ_n > DEPTH - 1) begin
      errors++;
      $display("FAIL fifo_occupancy at cycle %0d: got %0d, expected at most %0d", k, occ_n, DEPTH - 1);
    end
    if (rd && occ_h[k % 64] > 0) occ_n--;
    occ_h[(k + 1) % 64] = occ_n;

    wr_h[k % 64] = m_wrreq;
    pend = 0;
    for (int j = 0; j < LAT; j++) pend += int'(wr_h[(k - j + 64) % 64]);
    space = full ? 0 : (DEPTH - 1 - usedw - pend);
    if (space < 0) space = 0;
    m_err  = m_err | (m_wrreq & full);
    accept = v && m_busy;
    if (m_busy) begin
      if (accept) begin
        m_beats++;
        if (m_beats == BL || l) begin
          m_busy = 0;
          m_gap  = 1;
          m_count++;
        end
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else if (v && space >= BL) begin
      m_busy  = 1;
      m_beats = 0;
    end
    m_wrreq = accept;
    if (accept) m_data = d;

    k++;
    @(negedge wrclk);
    if (fifo_wrreq) begin
      wr_log_cyc.push_back(k);
      wr_log_dat.push_back(fifo_data);
    end
    compare_all();
  endtask

  // The task is entered at a negedge. It asserts aclr between clock
  // edges, checks that the outputs clear without waiting for a clock
  // edge, and releases aclr at a later negedge.
  task automatic do_reset();
    #2 aclr = 1'b1;
    #1;
    chk("rst_fifo_wrreq", fifo_wrreq, 0);
    chk("rst_src_ready", src_ready, 0);
    chk("rst_burst_active", burst_active, 0);
    chk("rst_burst_count", burst_count, 0);
    chk("rst_err_overflow", err_overflow, 0);
    chk("rst_fifo_data", fifo_data, 0);
    model_reset();
    repeat (2) @(negedge wrclk);
    aclr = 1'b0;
    compare_all();
  endtask

  initial begin
    int n;
    int k0;
    bit done;
    bit found;
    src_valid = 0; src_last = 0; src_data = '0; wrfull = 0; wrusedw = '0;
    model_reset();
    @(negedge wrclk);
    do_reset();

    // Full burst with data 0x11..0x14.
    wr_log_cyc.delete(); wr_log_dat.delete(); acc_cyc.delete();
    k0 = k;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      bit v;
      bit a;
      v = (n < 4);
      a = v && src_ready;
      if (a) acc_cyc.push_back(k);
      step(v, 0, 8'h11 + 8'(n), 0, -1, 0);
      if (a) n++;
    end
    chk("full_accepts", n, 4);
    chk("full_writes", wr_log_cyc.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < wr_log_cyc.size() && i < acc_cyc.size()) begin
        chk("full_data", wr_log_dat[i], 8'h11 + i);
        chk("full_latency", wr_log_cyc[i], acc_cyc[i] + 1);
      end
    end
    if (wr_log_cyc.size() > 0) chk("full_first_write", wr_log_cyc[0] - k0, 2);
    chk("full_burst_count", burst_count, 1);

    // Early last on beat 2.
    wr_log_cyc.delete(); wr_log_dat.delete();
    n = 0;
    for (int i = 0; i < 10; i++) begin
      bit v;
      bit a;
      v = (n < 2);
      a = v && src_ready;
      step(v, (n == 1), 8'h21 + 8'(n), 0, -1, 0);
      if (a) n++;
    end
    chk("last_writes", wr_log_cyc.size(), 2);
    if (wr_log_dat.size() >= 2) begin
      chk("last_data0", wr_log_dat[0], 8'h21);
      chk("last_data1", wr_log_dat[1], 8'h22);
    end
    chk("last_burst_count", burst_count, 2);

    // Space gate: wrusedw 12 blocks a burst, wrusedw 11 allows one.
    repeat (6) step(0, 0, 8'h00, 0, -1, 0);
    repeat (5) step(1, 0, 8'h31, 0, 12, 0);
    chk("gate_hold_ready", src_ready, 0);
    chk("gate_hold_count", burst_count, 2);
    step(1, 0, 8'h31, 0, 11, 0);
    chk("gate_open_ready", src_ready, 1);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      bit v;
      bit a;
      v = (n < 4);
      a = v && src_ready;
      step(v, 0, 8'h31 + 8'(n), 0, 11, 0);
      if (a) n++;
    end
    chk("gate_burst_count", burst_count, 3);

    // Random traffic against the lagged FIFO occupancy model.
    repeat (20) step(0, 0, 8'h00, 0, -1, 1);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 6) == 0, 8'($urandom),
           0, -1, $urandom_range(0, 9) < 3);
    end
    chk("random_no_err", err_overflow, 0);

    // Overflow flag: wrfull raised during a write cycle.
    repeat (40) step(0, 0, 8'h00, 0, -1, 1);
    done = 0;
    for (int i = 0; i < 16; i++) begin
      bit f;
      f = fifo_wrreq && !done;
      if (f) done = 1;
      step(1, 0, 8'($urandom), f, -1, 1);
    end
    chk("ovf_write_seen", done, 1);
    chk("ovf_set", err_overflow, 1);
    repeat (10) step(0, 0, 8'h00, 0, -1, 1);
    chk("ovf_sticky", err_overflow, 1);

    // Reset in the middle of a burst, with src_valid held high.
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (src_ready && fifo_wrreq) found = 1;
      else step(1, 0, 8'($urandom), 0, -1, 1);
    end
    chk("mid_burst_reached", found, 1);
    do_reset();
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 9) < 8, $urandom_range(0, 4) == 0, 8'($urandom),
           0, -1, $urandom_range(0, 9) < 4);
    end
    chk("final_no_err", err_overflow, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
